// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the PWM breathing-fade sequencer:
// FSM state encoding, ramp direction and the PWM IP register map.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DIV  = 3'd1,
    ST_WR_DUTY = 3'd2,
    ST_WR_EN   = 3'd3,
    ST_RUN     = 3'd4,
    ST_WR_DIS  = 3'd5
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // PWM IP slave register map
  localparam logic [1:0] ADDR_CLK_DIV = 2'd0;
  localparam logic [1:0] ADDR_DUTY    = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/pwm_fade_step.sv
// Triangle-ramp duty generator: holds the current duty and direction and
// advances them by one step per update, clamping at duty_max and at 0.
// cycle_done_o pulses for one cycle when a full breath returns to 0.
module pwm_fade_step
  import pwm_fade_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_i,
  input  logic          update_i,
  input  logic [DW-1:0] step_i,
  input  logic [DW-1:0] duty_max_i,
  output logic [DW-1:0] duty_o,
  output logic          cycle_done_o
);

  logic [DW-1:0] duty_q, duty_d;
  dir_e          dir_q, dir_d;
  logic          done_q, done_d;
  logic [DW:0]   sum_w;

  // One extra bit so duty+step can never wrap before the compare.
  assign sum_w = {1'b0, duty_q} + {1'b0, step_i};

  // Next duty/direction from the ramp rules.
  // NOTE: every variable gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    done_d = 1'b0;
    if (init_i) begin
      duty_d = '0;
      dir_d  = DIR_UP;
    end else if (update_i) begin
      if (duty_max_i == '0) begin
        // Degenerate ramp: stays at 0 and every update is a full breath.
        duty_d = '0;
        dir_d  = DIR_UP;
        done_d = 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (sum_w >= {1'b0, duty_max_i}) begin
          duty_d = duty_max_i;
          dir_d  = DIR_DOWN;
        end else begin
          duty_d = sum_w[DW-1:0];
        end
      end else begin
        if ({1'b0, duty_q} <= {1'b0, step_i}) begin
          duty_d = '0;
          dir_d  = DIR_UP;
          done_d = 1'b1;
        end else begin
          duty_d = duty_q - step_i;
        end
      end
    end
  end

  // Ramp state registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      dir_q  <= DIR_UP;
      done_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  assign duty_o       = duty_q;
  assign cycle_done_o = done_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Avalon-MM master sequencer driving the PWM IP: programs the period,
// then writes a triangle "breathing" duty ramp at a fixed interval until
// stopped, then disables the PWM.
// Optional feature: define PWM_FADE_IRQ_EN to build the breath-complete irq.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] cfg_period,
  input  logic [DW-1:0] cfg_duty_max,
  input  logic [DW-1:0] cfg_step,
  input  logic [IW-1:0] cfg_interval,
  output logic          m_chipselect,
  output logic          m_write,
  output logic [1:0]    m_address,
  output logic [DW-1:0] m_writedata,
  output logic [3:0]    m_byteenable,
  input  logic          m_waitrequest,
  output logic          busy,
  output logic [DW-1:0] duty_now,
  output logic          irq,
  input  logic          irq_ack
);

  state_e        state_q, state_d;
  logic [DW-1:0] period_q, dmax_q, step_q;
  logic [IW-1:0] ivl_q;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          stop_q, stop_d;
  logic          en_q, en_d;
  logic [DW-1:0] duty_now_q, duty_now_d;
  logic          latch_cfg, step_init, step_upd;
  logic          stop_pend;
  logic [IW-1:0] ivl_last;
  logic [DW-1:0] duty_w;
  logic          cycle_done;

  assign stop_pend = stop_q | stop;
  // An interval of 0 behaves as 1: the last RUN count is then 0.
  assign ivl_last  = (ivl_q == '0) ? '0 : ivl_q - IW'(1);

  pwm_fade_step #(.DW(DW)) u_step (
    .clk          (clk),
    .reset        (reset),
    .init_i       (step_init),
    .update_i     (step_upd),
    .step_i       (step_q),
    .duty_max_i   (dmax_q),
    .duty_o       (duty_w),
    .cycle_done_o (cycle_done)
  );

  // Sequencer next-state: write ordering, stall holding, stop handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    en_d       = en_q;
    duty_now_d = duty_now_q;
    latch_cfg  = 1'b0;
    step_init  = 1'b0;
    step_upd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start && !stop) begin
          state_d   = ST_WR_DIV;
          latch_cfg = 1'b1;
          step_init = 1'b1;
          en_d      = 1'b0;
        end
      end
      ST_WR_DIV: begin
        stop_d = stop_pend;
        if (!m_waitrequest) state_d = stop_pend ? ST_WR_DIS : ST_WR_DUTY;
      end
      ST_WR_DUTY: begin
        stop_d = stop_pend;
        if (!m_waitrequest) begin
          duty_now_d = duty_w;
          cnt_d      = '0;
          if (stop_pend)  state_d = ST_WR_DIS;
          else if (!en_q) state_d = ST_WR_EN;
          else            state_d = ST_RUN;
        end
      end
      ST_WR_EN: begin
        stop_d = stop_pend;
        if (!m_waitrequest) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = stop_pend ? ST_WR_DIS : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_pend) begin
          state_d = ST_WR_DIS;
        end else if (cnt_q == ivl_last) begin
          state_d  = ST_WR_DUTY;
          step_upd = 1'b1;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ST_WR_DIS: begin
        stop_d = 1'b0;
        if (!m_waitrequest) begin
          state_d    = ST_IDLE;
          duty_now_d = '0;
          en_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Avalon-MM master outputs decoded from the current state.
  always_comb begin
    m_chipselect = 1'b0;
    m_address    = ADDR_CLK_DIV;
    m_writedata  = '0;
    case (state_q)
      ST_WR_DIV: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_CLK_DIV;
        m_writedata  = period_q;
      end
      ST_WR_DUTY: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_DUTY;
        m_writedata  = duty_w;
      end
      ST_WR_EN: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_CTRL;
        m_writedata  = DW'(1);
      end
      ST_WR_DIS: begin
        m_chipselect = 1'b1;
        m_address    = ADDR_CTRL;
        m_writedata  = '0;
      end
      default: ;
    endcase
    m_write      = m_chipselect;
    m_byteenable = m_chipselect ? BE_ALL : 4'h0;
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      en_q       <= 1'b0;
      duty_now_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      en_q       <= en_d;
      duty_now_q <= duty_now_d;
    end
  end

  // Configuration snapshot taken on an accepted start only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      dmax_q   <= '0;
      step_q   <= '0;
      ivl_q    <= '0;
    end else if (latch_cfg) begin
      period_q <= cfg_period;
      dmax_q   <= cfg_duty_max;
      step_q   <= cfg_step;
      ivl_q    <= cfg_interval;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign duty_now = duty_now_q;

`ifdef PWM_FADE_IRQ_EN
  logic irq_q, irq_d;

  // Sticky breath-complete flag; a new completion beats a same-cycle ack.
  always_comb begin
    irq_d = cycle_done | (irq_q & ~irq_ack);
  end

  // Interrupt flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_ack ^ cycle_done;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: table-driven ramp runs, stall,
// stop and reset corner cases, randomized runs against a triangle model.
module tb_pwm_fade_ctrl;

  localparam int DW = 32;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_duty_max = '0;
  logic [DW-1:0] cfg_step = '0;
  logic [IW-1:0] cfg_interval = '0;
  logic          m_waitrequest = 1'b0;
  logic          irq_ack = 1'b0;
  logic          m_chipselect, m_write, busy, irq;
  logic [1:0]    m_address;
  logic [DW-1:0] m_writedata, duty_now;
  logic [3:0]    m_byteenable;

  pwm_fade_ctrl #(.DW(DW), .IW(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_period    (cfg_period),
    .cfg_duty_max  (cfg_duty_max),
    .cfg_step      (cfg_step),
    .cfg_interval  (cfg_interval),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .duty_now      (duty_now),
    .irq           (irq),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Accepted-write log: cycle offset from start, address, data.
  typedef struct {
    int          t;
    int          a;
    logic [63:0] d;
  } wr_t;

  wr_t           got[$];
  int            c0 = 0;
  bit            dn_pend = 0;
  logic [DW-1:0] dn_val = '0;
  bit            stall_en = 0;

  always @(negedge clk) begin
    if (dn_pend && !reset) check("duty_now", duty_now, dn_val);
    dn_pend = 0;
    if (!reset && m_chipselect && m_write && !m_waitrequest) begin
      got.push_back('{cyc - c0 + 1, int'(m_address), 64'(m_writedata)});
      check("byteenable", m_byteenable, 64'hF);
`ifndef PWM_FADE_IRQ_EN
      check("irq_off", irq, 0);
`endif
      if (m_address == 2'd1) begin
        dn_pend = 1;
        dn_val  = m_writedata;
      end
    end
  end

  // Duty after k updates: triangle up in steps clamped at max, down to 0.
  function automatic longint model_duty(input longint m, input longint s, input int k);
    longint u, i, j, v;
    if (m == 0 || s == 0) return 0;
    u = (m + s - 1) / s;
    i = (k - 1) % (2 * u);
    if (i < u) begin
      v = (i + 1) * s;
      return (v > m) ? m : v;
    end
    j = i - u + 1;
    v = m - j * s;
    return (v > 0) ? v : 0;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (stall_en) m_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_writes(input int n, input string name);
    int budget = 3000;
    while (got.size() < n && budget > 0) begin
      step_cycle();
      budget--;
    end
    if (got.size() < n) check({name, "_timeout"}, got.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int budget = 3000;
    while (busy && budget > 0) begin
      step_cycle();
      budget--;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic do_start(input int p, input int m, input int s, input int iv, input bit stall);
    step_cycle();
    cfg_period   = p;
    cfg_duty_max = m;
    cfg_step     = s;
    cfg_interval = iv;
    start        = 1'b1;
    if (stall) m_waitrequest = 1'b1;
    got.delete();
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    // Config changes while busy must be ignored.
    cfg_period   = $urandom;
    cfg_duty_max = $urandom;
    cfg_step     = $urandom;
    cfg_interval = IW'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_cs"}, m_chipselect, 0);
    check({name, "_wr"}, m_write, 0);
    check({name, "_addr"}, m_address, 0);
    check({name, "_data"}, m_writedata, 0);
    check({name, "_be"}, m_byteenable, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_duty_now"}, duty_now, 0);
    check({name, "_irq"}, irq, 0);
  endtask

  typedef struct {
    int period;
    int dmax;
    int step;
    int ivl;
    int n;
    int exp[12];
  } vec_t;

  vec_t vec[4];

  task automatic run_vec(input int i, input bit stall);
    int iv, sh, n, lim;
    wr_t e[$];
    n  = vec[i].n;
    iv = (vec[i].ivl == 0) ? 1 : vec[i].ivl;
    sh = stall ? 3 : 0;
    do_start(vec[i].period, vec[i].dmax, vec[i].step, vec[i].ivl, stall);
    if (stall) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("stall_cs", m_chipselect && m_write, 1);
        check("stall_addr", m_address, 0);
        check("stall_data", m_writedata, vec[i].period);
        @(posedge clk);
      end
      #1;
      m_waitrequest = 1'b0;
    end
    wait_writes(3 + n, "run");
    do_stop();
    wait_idle("run");
    e.push_back('{1 + sh, 0, 64'(vec[i].period)});
    e.push_back('{2 + sh, 1, 64'd0});
    e.push_back('{3 + sh, 2, 64'd1});
    for (int k = 1; k <= n; k++) e.push_back('{3 + sh + k * (iv + 1), 1, 64'(vec[i].exp[k-1])});
    check("run_count_ok", got.size() >= e.size() + 1, 1);
    lim = (got.size() < e.size()) ? got.size() : e.size();
    for (int j = 0; j < lim; j++) begin
      check($sformatf("v%0d_w%0d_t", i, j), got[j].t, e[j].t);
      check($sformatf("v%0d_w%0d_a", i, j), got[j].a, e[j].a);
      check($sformatf("v%0d_w%0d_d", i, j), got[j].d, e[j].d);
    end
    if (got.size() > 0) begin
      check("dis_addr", got[got.size()-1].a, 2);
      check("dis_data", got[got.size()-1].d, 0);
    end
    check("end_duty_now", duty_now, 0);
  endtask

  initial begin
    bit found, seen;
    vec[0] = '{100, 50, 10, 4, 12, '{10, 20, 30, 40, 50, 40, 30, 20, 10, 0, 10, 20}};
    vec[1] = '{7, 45, 10, 2, 11, '{10, 20, 30, 40, 45, 35, 25, 15, 5, 0, 10, 0}};
    vec[2] = '{5, 30, 0, 0, 3, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vec[3] = '{9, 0, 7, 3, 3, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Table-driven ramps, no stalls.
    for (int i = 0; i < 4; i++) run_vec(i, 1'b0);

    // Three-cycle stall on the first write shifts everything by 3.
    run_vec(0, 1'b1);

    // Stop during a ramp duty write: it completes, then disable.
    do_start(8, 30, 10, 2, 1'b0);
    found = 0;
    for (int b = 0; b < 200 && !found; b++) begin
      @(negedge clk);
      if (m_chipselect && m_address == 2'd1 && m_writedata != 0) found = 1;
    end
    check("stop_find", found, 1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_idle("stop");
    check("stop_n", got.size(), 5);
    if (got.size() == 5) begin
      check("stop_duty_t", got[3].t, 6);
      check("stop_duty_d", got[3].d, 10);
      check("stop_dis_t", got[4].t, 7);
      check("stop_dis_a", got[4].a, 2);
      check("stop_dis_d", got[4].d, 0);
    end
    check("stop_duty_now", duty_now, 0);

    // start and stop together in IDLE: nothing happens.
    step_cycle();
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_cs", m_chipselect, 0);

    // Randomized configs with random stalls against the triangle model.
    stall_en = 1;
    for (int r = 0; r < 6; r++) begin
      int p, m, s, iv, n, lim;
      p  = $urandom_range(1, 1000);
      m  = $urandom_range(0, 60);
      s  = $urandom_range(0, 25);
      iv = $urandom_range(0, 3);
      n  = 8;
      do_start(p, m, s, iv, 1'b0);
      wait_writes(3 + n, "rnd");
      do_stop();
      wait_idle("rnd");
      check("rnd_count_ok", got.size() >= 4 + n, 1);
      lim = (got.size() < 3 + n) ? got.size() : 3 + n;
      for (int j = 0; j < lim; j++) begin
        int          ea;
        logic [63:0] ed;
        if (j == 0)      begin ea = 0; ed = 64'(p); end
        else if (j == 1) begin ea = 1; ed = 0; end
        else if (j == 2) begin ea = 2; ed = 1; end
        else             begin ea = 1; ed = 64'(model_duty(m, s, j - 2)); end
        check($sformatf("rnd%0d_w%0d_a", r, j), got[j].a, ea);
        check($sformatf("rnd%0d_w%0d_d", r, j), got[j].d, ed);
      end
      if (got.size() > 0) begin
        check("rnd_dis_a", got[got.size()-1].a, 2);
        check("rnd_dis_d", got[got.size()-1].d, 0);
      end
    end
    stall_en      = 0;
    m_waitrequest = 1'b0;

    // Breath-complete interrupt.
    do_start(3, 20, 10, 1, 1'b0);
    found = 0;
    seen  = 0;
    for (int b = 0; b < 300 && !found; b++) begin
      @(negedge clk);
      if (m_chipselect && m_address == 2'd1) begin
        if (m_writedata != 0) seen = 1;
        else if (seen) found = 1;
      end
    end
    check("irq_find", found, 1);
    check("irq_pre", irq, 0);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
`ifdef PWM_FADE_IRQ_EN
    check("irq_set_wins", irq, 1);
    @(posedge clk);
    #1;
    check("irq_hold", irq, 1);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    irq_ack = 1'b0;
    check("irq_cleared", irq, 0);
`else
    check("irq_tied", irq, 0);
`endif
    do_stop();
    wait_idle("irq");

    // Reset in the middle of RUN, then replay the first ramp.
    do_start(vec[0].period, vec[0].dmax, vec[0].step, vec[0].ivl, 1'b0);
    wait_writes(4, "rst");
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_vec(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
